// File: rtl/nibrev_pkg.sv
// nibrev_pkg: shared widths, scheduler state type and a one-hot helper
// for the nibble-reverse scheduler and its arbiter.
package nibrev_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned MAX_REQ  = 8;   // largest supported requester count
    localparam int unsigned IDX_W    = 3;   // requester index width for MAX_REQ
    localparam int unsigned CNT_W    = 3;   // holds DP_LAT up to 7

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } sched_state_e;

    // Requester index -> one-hot vector, sized for the largest configuration.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/nibrev_rr_arb.sv
// nibrev_rr_arb: picks one requester among the set request bits.
// Default build is round robin, searching from ptr_i+1 upwards and wrapping
// to 0. Defining NIBREV_SCHED_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) and leaves ptr_i unused.
module nibrev_rr_arb
    import nibrev_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

`ifdef NIBREV_SCHED_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Fixed priority: the lowest set request index wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!vld_o && req_i[i]) begin
                vld_o    = 1'b1;
                idx_o    = IDX_W'(i);
                gnt_o[i] = 1'b1;
            end
        end
    end
`else
    // Round robin in two passes: indices above the pointer first, then
    // the wrapped range 0..pointer, so the last winner has lowest priority.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!vld_o && req_i[i] && (i > 32'(ptr_i))) begin
                vld_o    = 1'b1;
                idx_o    = IDX_W'(i);
                gnt_o[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!vld_o && req_i[i] && (i <= 32'(ptr_i))) begin
                vld_o    = 1'b1;
                idx_o    = IDX_W'(i);
                gnt_o[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/nibrev_sched.sv
// nibrev_sched: shares one nibble-reverse datapath among NREQ requesters.
// A request is accepted in IDLE, the nibble is driven to the datapath with a
// one-cycle enable (LOAD), the result is collected DP_LAT cycles later (WAIT)
// and held for the granted requester until its response handshake (RESP).
// Optional build macro: NIBREV_SCHED_FIXED_PRIO_EN (fixed priority arbiter,
// no round-robin pointer).
module nibrev_sched
    import nibrev_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DP_LAT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*NIBBLE_W-1:0] i_req_data,
    output logic [NREQ-1:0]          o_req_ready,
    output logic [NREQ-1:0]          o_rsp_valid,
    input  logic [NREQ-1:0]          i_rsp_ready,
    output logic [NIBBLE_W-1:0]      o_rsp_data,
    output logic                     o_dp_en,
    output logic [NIBBLE_W-1:0]      o_dp_a,
    input  logic [NIBBLE_W-1:0]      i_dp_a
);

    sched_state_e        state_q;
    logic [IDX_W-1:0]    gsel_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                dp_en_q;
    logic [NIBBLE_W-1:0] dp_a_q;
    logic [NIBBLE_W-1:0] rsp_data_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;
    logic [IDX_W-1:0]    arb_ptr;
    logic [NIBBLE_W-1:0] req_nib_d;
    logic                accept;

    nibrev_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i (i_req_valid),
        .ptr_i (arb_ptr),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

`ifdef NIBREV_SCHED_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IDX_W-1:0] ptr_q;

    // Round-robin pointer: remembers the last winner, moves only on accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= IDX_W'(NREQ - 1);
        end else if (accept) begin
            ptr_q <= arb_idx;
        end
    end

    assign arb_ptr = ptr_q;
`endif

    // Nibble of the arbitration winner, selected from the flat request bus.
    always_comb begin
        req_nib_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                req_nib_d = i_req_data[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    assign accept      = (state_q == IDLE) && arb_vld;
    assign o_req_ready = (i_rst_n && (state_q == IDLE)) ? arb_gnt : '0;
    assign o_rsp_valid = (state_q == RESP) ? NREQ'(onehot(gsel_q)) : '0;

    // Scheduler FSM with registered datapath drive and captured result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            gsel_q     <= '0;
            cnt_q      <= '0;
            dp_en_q    <= 1'b0;
            dp_a_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dp_a_q  <= req_nib_d;
                        dp_en_q <= 1'b1;
                        gsel_q  <= arb_idx;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    dp_en_q <= 1'b0;
                    cnt_q   <= CNT_W'(DP_LAT);
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_data_q <= i_dp_a;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    // o_rsp_valid is one-hot on gsel, so only that ready bit counts.
                    if (|(i_rsp_ready & o_rsp_valid)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_dp_en    = dp_en_q;
    assign o_dp_a     = dp_a_q;
    assign o_rsp_data = rsp_data_q;

endmodule

// File: tb/tb_nibrev_sched.sv
// tb_nibrev_sched: directed bench for nibrev_sched. DUT A uses DP_LAT=1,
// DUT B uses DP_LAT=3. Expected transactions are queued as stimulus is
// driven and retired when the DUT grants and responds.
module tb_nibrev_sched;

    typedef struct {
        int         idx;
        logic [3:0] req;
        logic [3:0] rsp;
    } txn_t;

    logic        clk;
    logic        rst_n;

    logic [3:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [15:0] a_req_data;
    logic [3:0]  a_rsp_data, a_dp_a, a_dp_q;
    logic        a_dp_en;

    logic [3:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [15:0] b_req_data;
    logic [3:0]  b_rsp_data, b_dp_a, b_s0, b_s1, b_s2;
    logic        b_dp_en;

    int          checks = 0;
    int          fails  = 0;
    int          rsp_cnt = 0;
    int          b_en_cnt = 0;
    int          k;
    int          base;
    logic [3:0]  b_en_a;
    logic        prev_en_a = 1'b0;
    logic        prev_en_b = 1'b0;
    txn_t        exp_q[$];
    txn_t        fly_q[$];
    txn_t        mt;
    logic [7:0]  mmask;

    nibrev_sched #(.NREQ(4), .DP_LAT(1)) u_dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (a_req_valid),
        .i_req_data  (a_req_data),
        .o_req_ready (a_req_ready),
        .o_rsp_valid (a_rsp_valid),
        .i_rsp_ready (a_rsp_ready),
        .o_rsp_data  (a_rsp_data),
        .o_dp_en     (a_dp_en),
        .o_dp_a      (a_dp_a),
        .i_dp_a      (a_dp_q)
    );

    nibrev_sched #(.NREQ(4), .DP_LAT(3)) u_dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (b_req_valid),
        .i_req_data  (b_req_data),
        .o_req_ready (b_req_ready),
        .o_rsp_valid (b_rsp_valid),
        .i_rsp_ready (b_rsp_ready),
        .o_rsp_data  (b_rsp_data),
        .o_dp_en     (b_dp_en),
        .o_dp_a      (b_dp_a),
        .i_dp_a      (b_s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Datapath models: enable-gated capture, then extra pipeline stages for B.
    always_ff @(posedge clk) begin
        if (a_dp_en) a_dp_q <= rev4(a_dp_a);
        if (b_dp_en) b_s0 <= rev4(b_dp_a);
        b_s1 <= b_s0;
        b_s2 <= b_s1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [3:0] req, input logic [3:0] rsp);
        txn_t t;
        t.idx = idx;
        t.req = req;
        t.rsp = rsp;
        exp_q.push_back(t);
    endtask

    task automatic wait_acc(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 8'(exp_q.size()), 8'd0);
    endtask

    task automatic wait_fly(input string tag);
        int n = 0;
        while ((fly_q.size() != 0 || exp_q.size() != 0) && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 8'(fly_q.size() + exp_q.size()), 8'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fly_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor A: grant order, datapath drive and responses against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((a_req_valid & a_req_ready) != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 8'(a_req_ready), 8'd0);
                end else begin
                    mt = exp_q.pop_front();
                    mmask = 8'd1 << mt.idx;
                    chk("grant", 8'(a_req_ready), mmask);
                    fly_q.push_back(mt);
                end
            end
            if (a_dp_en) begin
                chk("dp_en_twice", 8'(prev_en_a), 8'd0);
                if (fly_q.size() != 0) chk("dp_a", 8'(a_dp_a), 8'(fly_q[fly_q.size()-1].req));
                else chk("dp_en_unexpected", 8'(a_dp_en), 8'd0);
            end
            if (a_rsp_valid != 4'd0) begin
                chk("ready_in_resp", 8'(a_req_ready), 8'd0);
                if (fly_q.size() == 0) begin
                    chk("unexpected_rsp", 8'(a_rsp_valid), 8'd0);
                end else begin
                    mmask = 8'd1 << fly_q[0].idx;
                    chk("rsp_valid", 8'(a_rsp_valid), mmask);
                    chk("rsp_data", 8'(a_rsp_data), 8'(fly_q[0].rsp));
                    if ((a_rsp_valid & a_rsp_ready) != 4'd0) begin
                        void'(fly_q.pop_front());
                        rsp_cnt++;
                    end
                end
            end
            prev_en_a = a_dp_en;
        end else begin
            prev_en_a = 1'b0;
        end
    end

    // Monitor B: enable pulse count and the nibble presented with it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b_dp_en) begin
                b_en_cnt++;
                b_en_a = b_dp_a;
                chk("b_dp_en_twice", 8'(prev_en_b), 8'd0);
            end
            prev_en_b = b_dp_en;
        end else begin
            prev_en_b = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        a_req_valid = 4'hF;
        a_req_data  = '0;
        a_rsp_ready = '0;
        b_req_valid = '0;
        b_req_data  = '0;
        b_rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 8'(a_req_ready), 8'd0);
        chk("rst_dp_en", 8'(a_dp_en), 8'd0);
        chk("rst_dp_a", 8'(a_dp_a), 8'd0);
        chk("rst_rsp_data", 8'(a_rsp_data), 8'd0);
        chk("rst_rsp_valid", 8'(a_rsp_valid), 8'd0);
        a_req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single request from requester 0, latency to response
        push(0, 4'b0001, 4'b1000);
        a_req_data  = 16'h0001;
        a_req_valid = 4'b0001;
        a_rsp_ready = 4'hF;
        @(negedge clk);
        chk("t1_ready", 8'(a_req_ready), 8'd1);
        @(posedge clk); #1;
        a_req_valid = '0;
        k = 1;
        while (a_rsp_valid == 4'd0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t1_latency", 8'(k), 8'd3);
        chk("t1_rsp_valid", 8'(a_rsp_valid), 8'd1);
        chk("t1_rsp_data", 8'(a_rsp_data), 8'h8);
        wait_fly("t1_done");

`ifndef NIBREV_SCHED_FIXED_PRIO_EN
        // 2: all requesters valid, round-robin order 0,1,2,3,0 from reset
        do_reset();
        base = rsp_cnt;
        push(0, 4'h1, 4'h8);
        push(1, 4'h2, 4'h4);
        push(2, 4'h3, 4'hC);
        push(3, 4'h4, 4'h2);
        push(0, 4'h1, 4'h8);
        a_req_data  = 16'h4321;
        a_req_valid = 4'hF;
        a_rsp_ready = 4'hF;
        wait_acc("t2_accepts");
        a_req_valid = '0;
        wait_fly("t2_done");
        chk("t2_rsp_count", 8'(rsp_cnt - base), 8'd5);
`endif

        // 3: response back-pressure on requester 2, foreign ready ignored
        push(2, 4'b1101, 4'b1011);
        a_req_data  = 16'h0D01;
        a_req_valid = 4'b0100;
        a_rsp_ready = 4'b0001;
        wait_acc("t3_accept2");
        a_req_valid = 4'b0001;
        push(0, 4'h1, 4'h8);
        k = 0;
        while (a_rsp_valid == 4'd0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", 8'(a_rsp_valid), 8'h04);
            chk("t3_hold_data", 8'(a_rsp_data), 8'hB);
            chk("t3_no_grant", 8'(a_req_ready), 8'd0);
            @(posedge clk); #1;
        end
        chk("t3_hold_valid6", 8'(a_rsp_valid), 8'h04);
        a_rsp_ready = 4'b0101;
        @(posedge clk); #1;
        chk("t3_released", 8'(a_rsp_valid), 8'd0);
        wait_acc("t3_accept0");
        a_req_valid = '0;
        wait_fly("t3_done");

        // 4: reset during WAIT discards the transaction
        push(3, 4'h5, 4'hA);
        a_req_data  = 16'h5000;
        a_req_valid = 4'b1000;
        a_rsp_ready = 4'hF;
        wait_acc("t4_accept3");
        a_req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_dp_en", 8'(a_dp_en), 8'd0);
        chk("t4_rst_rsp_valid", 8'(a_rsp_valid), 8'd0);
        fly_q.delete();
        @(posedge clk); #1;
        chk("t4_no_rsp", 8'(a_rsp_valid), 8'd0);
        rst_n = 1'b1;
        push(1, 4'b0110, 4'b0110);
        a_req_data  = 16'h0060;
        a_req_valid = 4'b0010;
        wait_acc("t4_accept1");
        a_req_valid = '0;
        wait_fly("t4_done");

        // 4b: reset while a response is pending drops o_rsp_valid at once
        push(0, 4'h1, 4'h8);
        a_req_data  = 16'h0001;
        a_req_valid = 4'b0001;
        a_rsp_ready = '0;
        wait_acc("t4b_accept");
        a_req_valid = '0;
        k = 0;
        while (a_rsp_valid == 4'd0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t4b_pending", 8'(a_rsp_valid), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("t4b_rst_rsp_valid", 8'(a_rsp_valid), 8'd0);
        fly_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_rsp_ready = 4'hF;
        @(posedge clk); #1;
        chk("t4b_discarded", 8'(a_rsp_valid), 8'd0);

        // 5: DP_LAT=3 on DUT B
        b_req_data  = 16'h0030;
        b_req_valid = 4'b0010;
        b_rsp_ready = 4'hF;
        @(negedge clk);
        chk("t5_ready", 8'(b_req_ready), 8'h02);
        @(posedge clk); #1;
        b_req_valid = '0;
        k = 1;
        while (b_rsp_valid == 4'd0 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t5_latency", 8'(k), 8'd5);
        chk("t5_rsp_valid", 8'(b_rsp_valid), 8'h02);
        chk("t5_rsp_data", 8'(b_rsp_data), 8'hC);
        @(posedge clk); #1;
        chk("t5_rsp_done", 8'(b_rsp_valid), 8'd0);
        chk("t5_en_cycles", 8'(b_en_cnt), 8'd1);
        chk("t5_en_data", 8'(b_en_a), 8'h3);

`ifdef NIBREV_SCHED_FIXED_PRIO_EN
        // 6: fixed priority, requester 3 starves behind requester 0
        do_reset();
        push(0, 4'h1, 4'h8);
        push(0, 4'h1, 4'h8);
        push(0, 4'h1, 4'h8);
        a_req_data  = 16'h4001;
        a_req_valid = 4'b1001;
        a_rsp_ready = 4'hF;
        wait_acc("t6_accepts");
        a_req_valid = '0;
        wait_fly("t6_done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
